// File: rtl/token_divider_if.sv
// Handshake bundle for token_divider: token inputs/outputs plus the
// configuration and status signals.
interface token_divider_if #(
    parameter int CHANNELS = 4,
    parameter int DIV_W    = 4
);
    logic [CHANNELS-1:0] a;
    logic                cfg_we;
    logic [DIV_W-1:0]    cfg_div;
    logic                cfg_mode;
    logic                clear;
    logic [CHANNELS-1:0] b;
    logic [DIV_W-1:0]    div_active;
    logic                cfg_err;

    modport master (
        output a, cfg_we, cfg_div, cfg_mode, clear,
        input  b, div_active, cfg_err
    );

    modport slave (
        input  a, cfg_we, cfg_div, cfg_mode, clear,
        output b, div_active, cfg_err
    );
endinterface

// File: rtl/token_divider.sv
// Per-channel token divider: passes exactly one of every D tokens on each
// channel, selecting either the first or the last token of each group.
module token_divider #(
    parameter int CHANNELS = 4,
    parameter int DIV_W    = 4
) (
    input  logic          clk,
    input  logic          rst,
    token_divider_if.slave bus
);
    typedef enum logic {
        MODE_LAST  = 1'b0,
        MODE_FIRST = 1'b1
    } mode_t;

    logic [DIV_W-1:0]    cnt [CHANNELS];
    logic [DIV_W-1:0]    div_q;
    mode_t               mode;
    logic                err_q;
    logic [DIV_W-1:0]    last_cnt;
    logic                cfg_accept;
    logic                cfg_reject;
    logic [CHANNELS-1:0] b_next;

    assign last_cnt   = div_q - DIV_W'(1);
    assign cfg_accept = bus.cfg_we && (bus.cfg_div != '0);
    assign cfg_reject = bus.cfg_we && (bus.cfg_div == '0);

    // Output uses the divisor/mode currently in effect, even during a config write.
    always_comb begin
        b_next = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (mode == MODE_FIRST) begin
                b_next[i] = bus.a[i] & (cnt[i] == '0);
            end else begin
                b_next[i] = bus.a[i] & (cnt[i] == last_cnt);
            end
        end
    end

    assign bus.b          = b_next;
    assign bus.div_active = div_q;
    assign bus.cfg_err    = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
        end else if (cfg_accept || bus.clear) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.a[i]) begin
                    cnt[i] <= (cnt[i] == last_cnt) ? '0 : cnt[i] + DIV_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= DIV_W'(2);
            mode  <= MODE_LAST;
        end else if (cfg_accept) begin
            div_q <= bus.cfg_div;
            mode  <= mode_t'(bus.cfg_mode);
        end
    end

    // A rejected write in the same cycle as clear still leaves the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (cfg_reject) begin
            err_q <= 1'b1;
        end else if (bus.clear) begin
            err_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_token_divider.sv
// Self-checking bench for token_divider: reference model feeds a scoreboard
// queue, plus directed token/pass sequences.
module tb_token_divider;
    localparam int CH = 4;
    localparam int DW = 4;

    logic clk;
    logic rst;

    token_divider_if #(.CHANNELS(CH), .DIV_W(DW)) bus ();

    token_divider #(.CHANNELS(CH), .DIV_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [CH-1:0] exp_q [$];

    int m_cnt [CH];
    int m_div;
    bit m_mode;
    bit m_err;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < CH; i++) m_cnt[i] = 0;
        m_div  = 2;
        m_mode = 1'b0;
        m_err  = 1'b0;
    endtask

    function automatic logic [CH-1:0] modelB(input logic [CH-1:0] a_in);
        logic [CH-1:0] r;
        r = '0;
        for (int i = 0; i < CH; i++) begin
            if (a_in[i]) r[i] = m_mode ? (m_cnt[i] == 0) : (m_cnt[i] == m_div - 1);
        end
        return r;
    endfunction

    task automatic modelStep(input logic [CH-1:0] a_in, input logic we,
                             input logic [DW-1:0] div, input logic mode, input logic clr);
        if (we && div != 0) begin
            m_div  = int'(div);
            m_mode = mode;
            for (int i = 0; i < CH; i++) m_cnt[i] = 0;
        end else if (clr) begin
            for (int i = 0; i < CH; i++) m_cnt[i] = 0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (a_in[i]) m_cnt[i] = (m_cnt[i] + 1) % m_div;
            end
        end
        if (we && div == 0) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
    endtask

    // One clock of stimulus: expected b is queued at drive time and popped at sample time.
    task automatic applyStimulus(input logic [CH-1:0] a_in, input logic we,
                                 input logic [DW-1:0] div, input logic mode,
                                 input logic clr, output logic [CH-1:0] b_seen);
        logic [CH-1:0] exp_b;
        bus.a        = a_in;
        bus.cfg_we   = we;
        bus.cfg_div  = div;
        bus.cfg_mode = mode;
        bus.clear    = clr;
        exp_q.push_back(modelB(a_in));
        #2;
        b_seen = bus.b;
        if (exp_q.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            exp_b = exp_q.pop_front();
            checkOutput("b", 32'(bus.b), 32'(exp_b));
        end
        @(posedge clk);
        #1;
        modelStep(a_in, we, div, mode, clr);
        bus.a      = '0;
        bus.cfg_we = 1'b0;
        bus.clear  = 1'b0;
        checkOutput("div_active", 32'(bus.div_active), 32'(m_div));
        checkOutput("cfg_err", 32'(bus.cfg_err), 32'(m_err));
    endtask

    task automatic writeCfg(input logic [DW-1:0] div, input logic mode);
        logic [CH-1:0] bs;
        applyStimulus('0, 1'b1, div, mode, 1'b0, bs);
    endtask

    // Drive a time-ordered bit string (MSB first) on one channel and compare the passed pattern.
    task automatic runSeq(input string tag, input int ch, input logic [31:0] a_bits,
                          input logic [31:0] b_bits, input int n);
        logic [31:0]   obs;
        logic [CH-1:0] a_vec;
        logic [CH-1:0] bs;
        obs = '0;
        for (int k = n - 1; k >= 0; k--) begin
            a_vec     = '0;
            a_vec[ch] = a_bits[k];
            applyStimulus(a_vec, 1'b0, '0, 1'b0, 1'b0, bs);
            obs[k] = bs[ch];
        end
        checkOutput(tag, obs, b_bits);
    endtask

    task automatic doReset();
        rst          = 1'b1;
        bus.a        = '0;
        bus.cfg_we   = 1'b0;
        bus.cfg_div  = '0;
        bus.cfg_mode = 1'b0;
        bus.clear    = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_div_active", 32'(bus.div_active), 32'd2);
        checkOutput("reset_cfg_err", 32'(bus.cfg_err), 32'd0);
        checkOutput("reset_b", 32'(bus.b), 32'd0);
        rst = 1'b0;
        modelReset();
    endtask

    initial begin
        logic [CH-1:0] bs;
        logic [7:0]    obs0;
        logic [7:0]    obs1;

        modelReset();
        doReset();

        // Default halving
        runSeq("halving_default", 0, 32'b1100_1110_1000_1111, 32'b0100_0100_1000_0101, 16);

        // D=3 in both selection modes
        writeCfg(4'd3, 1'b0);
        runSeq("d3_last", 0, 32'b111_111_111, 32'b001_001_001, 9);
        writeCfg(4'd3, 1'b1);
        runSeq("d3_first", 0, 32'b111_111_111, 32'b100_100_100, 9);

        // Mid-group reconfiguration: that cycle uses the old D/mode and is not counted
        writeCfg(4'd4, 1'b1);
        runSeq("d4_first_three", 0, 32'b111, 32'b100, 3);
        applyStimulus(4'b0001, 1'b1, 4'd2, 1'b0, 1'b0, bs);
        checkOutput("reconfig_cycle_b0", 32'(bs[0]), 32'd0);
        runSeq("after_reconfig", 0, 32'b1111, 32'b0101, 4);

        // D=1 passes everything in both modes; D=15 is the top of the range
        writeCfg(4'd1, 1'b0);
        runSeq("d1_last", 2, 32'b1011, 32'b1011, 4);
        writeCfg(4'd1, 1'b1);
        runSeq("d1_first", 3, 32'b1101, 32'b1101, 4);
        writeCfg(4'd15, 1'b0);
        runSeq("d15_last", 1, 32'hFFFF, 32'b0000_0000_0000_0010, 16);

        // Illegal divisor is flagged and ignored
        doReset();
        writeCfg(4'd0, 1'b1);
        checkOutput("bad_cfg_err", 32'(bus.cfg_err), 32'd1);
        checkOutput("bad_cfg_div", 32'(bus.div_active), 32'd2);
        runSeq("halving_after_bad_cfg", 0, 32'b1111, 32'b0101, 4);
        applyStimulus('0, 1'b0, '0, 1'b0, 1'b1, bs);
        checkOutput("clear_err", 32'(bus.cfg_err), 32'd0);

        // Set wins over clear; clear with a legal write applies the config
        applyStimulus('0, 1'b1, 4'd0, 1'b0, 1'b1, bs);
        checkOutput("set_beats_clear", 32'(bus.cfg_err), 32'd1);
        runSeq("prime_one_token", 0, 32'b1, 32'b0, 1);
        applyStimulus(4'b0001, 1'b1, 4'd3, 1'b0, 1'b1, bs);
        checkOutput("clear_with_cfg_div", 32'(bus.div_active), 32'd3);
        runSeq("clear_with_cfg_seq", 0, 32'b111, 32'b001, 3);

        // Channel independence with D=2
        writeCfg(4'd2, 1'b0);
        obs0 = '0;
        obs1 = '0;
        for (int k = 7; k >= 0; k--) begin
            applyStimulus({2'b00, ((k % 2) == 1), 1'b1}, 1'b0, '0, 1'b0, 1'b0, bs);
            obs0[k] = bs[0];
            obs1[k] = bs[1];
        end
        checkOutput("indep_ch0", 32'(obs0), 32'b0101_0101);
        checkOutput("indep_ch1", 32'(obs1), 32'b0010_0010);

        // Asynchronous reset mid-sequence with D=3
        writeCfg(4'd3, 1'b0);
        runSeq("pre_reset_tokens", 0, 32'b11, 32'b00, 2);
        bus.a = 4'b0001;
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_div", 32'(bus.div_active), 32'd2);
        checkOutput("async_rst_b", 32'(bus.b), 32'd0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        bus.a = '0;
        modelReset();
        runSeq("post_reset_halving", 0, 32'b1111, 32'b0101, 4);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            applyStimulus(CH'($urandom), ($urandom_range(0, 15) == 0), DW'($urandom_range(0, 15)),
                          1'($urandom), ($urandom_range(0, 24) == 0), bs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/token_divider.md
TOKEN_DIVIDER -- requirements
Module: token_divider

Interface
REQ-001 Parameter CHANNELS, default 4, number of independent serial token channels (>=1).
REQ-002 Parameter DIV_W, default 4, divisor width; legal divisor range 1..2^DIV_W-1.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port a  input  CHANNELS  incoming token per channel; a[i]=1 in a cycle is one token.
REQ-006 Port cfg_we  input  1  configuration write strobe, one cycle.
REQ-007 Port cfg_div  input  DIV_W  requested divisor D, sampled when cfg_we=1.
REQ-008 Port cfg_mode  input  1  requested select mode (0=LAST, 1=FIRST), sampled when cfg_we=1.
REQ-009 Port clear  input  1  synchronous clear of counters and error flag.
REQ-010 Port b  output  CHANNELS  passed token per channel.
REQ-011 Port div_active  output  DIV_W  divisor currently in effect.
REQ-012 Port cfg_err  output  1  sticky flag, illegal configuration attempted.

Function
REQ-013 Each channel i SHALL hold a token counter cnt[i] of DIV_W bits, range 0..D-1.
REQ-014 On a clock edge with a[i]=1, cnt[i] SHALL become 0 if cnt[i]==D-1, else cnt[i]+1; with a[i]=0, cnt[i] holds.
REQ-015 Mode LAST: b[i] SHALL equal a[i] & (cnt[i]==D-1), combinational, zero latency.
REQ-016 Mode FIRST: b[i] SHALL equal a[i] & (cnt[i]==0), combinational, zero latency.
REQ-017 Exactly one of every D tokens per channel SHALL be passed; D=1 passes every token unchanged in both modes.
REQ-018 Channels SHALL be fully independent; token activity on one channel never alters another's cnt or b.
REQ-019 cfg_we=1 with cfg_div!=0 SHALL, at that edge, load div_active<=cfg_div and mode<=cfg_mode, and zero all cnt[i].
REQ-020 cfg_we=1 with cfg_div==0 SHALL leave div_active, mode and all cnt unchanged and set cfg_err<=1.
REQ-021 In the cycle of an accepted cfg_we, b SHALL be computed with the old divisor and mode; that cycle's tokens SHALL NOT be counted (counters zeroed).
REQ-022 clear=1 SHALL zero all cnt[i] and cfg_err at the edge; div_active and mode are retained.
REQ-023 clear=1 and cfg_we=1 together: the legal config SHALL be applied and counters zeroed; with cfg_div==0, cfg_err SHALL end at 1 (set wins over clear).
REQ-024 cfg_err SHALL remain 1 until clear or rst.
REQ-025 b SHALL never be 1 while the corresponding a[i]=0.

Reset
REQ-026 While rst=1: all cnt[i]=0, div_active=2, mode=LAST, cfg_err=0; b is 0 for all channels whose a[i]=0.
REQ-027 Reset defaults SHALL reproduce the halving behaviour: every second token passed per channel.
REQ-028 Reset asserted mid-sequence SHALL discard counter state and any programmed configuration immediately (asynchronously).

Verification
REQ-029 After reset, a[0] = 110_011_101_000_1111 -> b[0] = 010_001_001_000_0101.
REQ-030 cfg_div=3, cfg_mode=0 written, then a[0]=1 for 9 cycles -> b[0]=001_001_001; cfg_mode=1 rerun -> b[0]=100_100_100.
REQ-031 cfg_div=0 written -> cfg_err=1, div_active stays 2, halving continues; then clear -> cfg_err=0.
REQ-032 Channel independence: a[0] constant 1, a[1] toggles 1010..., D=2 -> b[0]=0101..., b[1] passes every second a[1] token only.
REQ-033 Mid-group reconfig: D=4, three tokens on a[0], write D=2 with a[0]=1 in same cycle -> that cycle b[0]=0, next tokens yield b[0]=0101.
REQ-034 rst pulse after two tokens with D=3 -> div_active=2, cnt=0, next tokens give b=0101.
